// File: rtl/keccak_out_serializer_if.sv
// Handshake and data bundle of the Keccak output serializer.
// The slave modport is the serializer's side; the master modport is the producer/consumer side.
interface keccak_out_serializer_if #(
  parameter int DW  = 200,
  parameter int IXW = 3
);
  logic            pushin;
  logic [1599:0]   din;
  logic [7:0]      tagin;
  logic [IXW-1:0]  nchin;
  logic            stopin;
  logic            stopout;
  logic            pushout;
  logic [DW-1:0]   dout;
  logic [IXW-1:0]  doutix;
  logic [7:0]      tagout;
  logic            lastout;

  modport master (
    output pushin, din, tagin, nchin, stopout,
    input  stopin, pushout, dout, doutix, tagout, lastout
  );

  modport slave (
    input  pushin, din, tagin, nchin, stopout,
    output stopin, pushout, dout, doutix, tagout, lastout
  );
endinterface

// File: rtl/keccak_out_serializer.sv
// Splits 1600-bit Keccak states into DW-bit chunks, using an ACTIVE slot and a PENDING slot.
// state | meaning
// IDLE  | ACTIVE slot empty, pushout low
// SEND  | ACTIVE slot holds a block, one chunk presented per cycle
module keccak_out_serializer #(
  parameter int DW     = 200,
  parameter int NCHUNK = 8,
  parameter int IXW    = 3
) (
  input  logic clk,
  input  logic reset,
  keccak_out_serializer_if.slave bus
);
  localparam logic [0:0]     IDLE    = 1'b0;
  localparam logic [0:0]     SEND    = 1'b1;
  localparam logic [IXW:0]   NCH_LIM = (IXW+1)'(NCHUNK);
  localparam logic [IXW-1:0] NCH_MAX = IXW'(NCHUNK - 1);

  logic [0:0]                 state;
  logic [1599:0]              act_st;
  logic [1599:0]              pnd_st;
  logic [7:0]                 pnd_tag;
  logic [IXW-1:0]             act_nch;
  logic [IXW-1:0]             pnd_nch;
  logic                       pnd_vld;
  logic [IXW-1:0]             ix;
  logic [DW-1:0]              dout_r;
  logic [7:0]                 tag_r;

  logic [NCHUNK-1:0][DW-1:0]  act_chunks;
  logic [IXW-1:0]             ix_nx;
  logic [IXW-1:0]             nch_in;
  logic                       busy;
  logic                       xfer;
  logic                       fin;
  logic                       accept;
  logic                       load_in;

  assign act_chunks = act_st[DW*NCHUNK-1:0];
  assign ix_nx      = ix + 1'b1;
  assign nch_in     = ({1'b0, bus.nchin} >= NCH_LIM) ? NCH_MAX : bus.nchin;

  assign busy    = (state == SEND);
  assign xfer    = busy & ~bus.stopout;
  assign fin     = xfer & (ix == act_nch);
  assign accept  = bus.pushin & ~pnd_vld;
  // A new block goes straight to ACTIVE when it is free now or frees up this edge.
  assign load_in = accept & (~busy | fin);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      act_st  <= '0;
      pnd_st  <= '0;
      pnd_tag <= '0;
      act_nch <= '0;
      pnd_nch <= '0;
      pnd_vld <= 1'b0;
      ix      <= '0;
      dout_r  <= '0;
      tag_r   <= '0;
    end else begin
      if (fin) begin
        ix <= '0;
        if (pnd_vld) begin
          act_st  <= pnd_st;
          act_nch <= pnd_nch;
          pnd_vld <= 1'b0;
          dout_r  <= pnd_st[DW-1:0];
          tag_r   <= pnd_tag;
        end else if (!load_in) begin
          state <= IDLE;
        end
      end else if (xfer) begin
        ix     <= ix_nx;
        dout_r <= act_chunks[ix_nx];
      end

      if (load_in) begin
        state   <= SEND;
        act_st  <= bus.din;
        act_nch <= nch_in;
        dout_r  <= bus.din[DW-1:0];
        tag_r   <= bus.tagin;
      end else if (accept) begin
        pnd_vld <= 1'b1;
        pnd_st  <= bus.din;
        pnd_tag <= bus.tagin;
        pnd_nch <= nch_in;
      end
    end
  end

  assign bus.stopin  = pnd_vld;
  assign bus.pushout = busy;
  assign bus.dout    = dout_r;
  assign bus.doutix  = ix;
  assign bus.tagout  = tag_r;
  assign bus.lastout = busy & (ix == act_nch);
endmodule

// File: tb/tb_keccak_out_serializer.sv
// Self-checking bench for keccak_out_serializer: scripted table, corner sequences, random traffic.
module tb_keccak_out_serializer;
  localparam int DW     = 200;
  localparam int NCHUNK = 8;
  localparam int IXW    = 3;

  logic clk;
  logic reset;

  keccak_out_serializer_if #(.DW(DW), .IXW(IXW)) bus ();

  keccak_out_serializer #(.DW(DW), .NCHUNK(NCHUNK), .IXW(IXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1599:0] st;
    logic [7:0]    tag;
    int            nch;
  } blk_t;

  // Reference: queue of accepted, not yet fully emitted blocks; front is being emitted.
  blk_t          q[$];
  int            ptr = 0;
  int            xfers = 0;
  logic [DW-1:0] last_dout = '0;
  logic [7:0]    last_tag = '0;

  typedef struct {
    logic       rst;
    logic       push;
    logic [2:0] nch;
    logic [7:0] tag;
    logic       stp;
    logic       e_po;
    logic       e_si;
    logic [2:0] e_ix;
    logic       e_last;
    logic [7:0] e_tag;
  } row_t;

  row_t tbl[19];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_check();
    chk("pushout", 256'(bus.pushout), 256'(q.size() > 0));
    chk("stopin", 256'(bus.stopin), 256'(q.size() == 2));
    if (q.size() > 0) begin
      last_dout = q[0].st[ptr*DW +: DW];
      last_tag  = q[0].tag;
      chk("dout", 256'(bus.dout), 256'(last_dout));
      chk("doutix", 256'(bus.doutix), 256'(ptr));
      chk("tagout", 256'(bus.tagout), 256'(last_tag));
      chk("lastout", 256'(bus.lastout), 256'(ptr == q[0].nch));
    end else begin
      chk("idle_dout", 256'(bus.dout), 256'(last_dout));
      chk("idle_tag", 256'(bus.tagout), 256'(last_tag));
      chk("idle_ix", 256'(bus.doutix), 256'(0));
      chk("idle_last", 256'(bus.lastout), 256'(0));
    end
  endtask

  task automatic step(input logic r, input logic p, input logic [2:0] n,
                      input logic [7:0] t, input logic s, input logic [1599:0] d);
    bit   accept;
    blk_t b;
    reset       = r;
    bus.pushin  = p;
    bus.nchin   = n;
    bus.tagin   = t;
    bus.stopout = s;
    bus.din     = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      ptr       = 0;
      last_dout = '0;
      last_tag  = '0;
    end else begin
      accept = p && (q.size() < 2);
      if (q.size() > 0 && !s) begin
        xfers++;
        if (ptr == q[0].nch) begin
          void'(q.pop_front());
          ptr = 0;
        end else begin
          ptr++;
        end
      end
      if (accept) begin
        b.st  = d;
        b.tag = t;
        b.nch = (int'(n) >= NCHUNK) ? NCHUNK - 1 : int'(n);
        q.push_back(b);
      end
    end
    @(negedge clk);
    model_check();
  endtask

  initial begin
    logic [1599:0] d;
    int            base;

    reset = 1'b1;
    bus.pushin = 1'b0; bus.nchin = '0; bus.tagin = '0; bus.stopout = 1'b0; bus.din = '0;

    // rst push nch tag stp | pushout stopin ix last tag
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'hA5};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 8'hA5};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'hA5};
    tbl[4]  = '{1'b0, 1'b1, 3'd2, 8'h11, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h11};
    tbl[5]  = '{1'b0, 1'b1, 3'd0, 8'h22, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 8'h11};
    tbl[6]  = '{1'b0, 1'b1, 3'd0, 8'h33, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h11};
    tbl[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 8'h11};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h22};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h22};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 8'h44, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h44};
    tbl[11] = '{1'b0, 1'b1, 3'd1, 8'h55, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h55};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 8'h55};
    tbl[13] = '{1'b0, 1'b1, 3'd7, 8'h66, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h66};
    tbl[14] = '{1'b0, 1'b1, 3'd3, 8'h77, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h66};
    tbl[15] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'h66};
    tbl[16] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'h66};
    tbl[17] = '{1'b1, 1'b1, 3'd0, 8'h88, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
    tbl[18] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};

    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].push, tbl[i].nch, tbl[i].tag, tbl[i].stp, rand_state());
      chk($sformatf("tbl%0d_pushout", i), 256'(bus.pushout), 256'(tbl[i].e_po));
      chk($sformatf("tbl%0d_stopin", i),  256'(bus.stopin),  256'(tbl[i].e_si));
      chk($sformatf("tbl%0d_doutix", i),  256'(bus.doutix),  256'(tbl[i].e_ix));
      chk($sformatf("tbl%0d_lastout", i), 256'(bus.lastout), 256'(tbl[i].e_last));
      chk($sformatf("tbl%0d_tagout", i),  256'(bus.tagout),  256'(tbl[i].e_tag));
    end

    // Full 8-chunk block with a 3-cycle stall at index 4.
    d = rand_state();
    step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, '0);
    base = xfers;
    step(1'b0, 1'b1, 3'd7, 8'h9C, 1'b0, d);
    chk("seq_ix0", 256'(bus.doutix), 256'(0));
    chk("seq_dout0", 256'(bus.dout), 256'(d[DW-1:0]));
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, '0);
      chk($sformatf("seq_ix%0d", k), 256'(bus.doutix), 256'(k));
      chk($sformatf("seq_dout%0d", k), 256'(bus.dout), 256'(d[k*DW +: DW]));
      chk($sformatf("seq_last%0d", k), 256'(bus.lastout), 256'(0));
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, '0);
      chk("stall_ix", 256'(bus.doutix), 256'(4));
      chk("stall_dout", 256'(bus.dout), 256'(d[4*DW +: DW]));
      chk("stall_pushout", 256'(bus.pushout), 256'(1));
    end
    for (int k = 5; k <= 7; k++) begin
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, '0);
      chk($sformatf("seq_ix%0d", k), 256'(bus.doutix), 256'(k));
      chk($sformatf("seq_dout%0d", k), 256'(bus.dout), 256'(d[k*DW +: DW]));
    end
    chk("seq_last7", 256'(bus.lastout), 256'(1));
    step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, '0);
    chk("seq_idle_pushout", 256'(bus.pushout), 256'(0));
    chk("seq_xfer_count", 256'(xfers - base), 256'(8));
    chk("seq_idle_dout", 256'(bus.dout), 256'(d[7*DW +: DW]));

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 3) == 0), rand_state());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keccak_out_serializer.md
KECCAK_OUT_SERIALIZER -- requirements
Module: keccak_out_serializer

Interface
REQ-001 SHALL have parameter DW, default 200, output chunk width in bits.
REQ-002 SHALL have parameter NCHUNK, default 8, maximum chunks per block; DW*NCHUNK <= 1600.
REQ-003 SHALL have parameter IXW, default 3, chunk-index width; 2**IXW >= NCHUNK.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pushin  input  1  offers one 1600-bit Keccak state.
REQ-007 SHALL have port din  input  1600  state; lane (x,y) at bits 64*(5y+x)+63 : 64*(5y+x).
REQ-008 SHALL have port tagin  input  8  tag accompanying din.
REQ-009 SHALL have port nchin  input  IXW  number of chunks to emit minus one, sampled with din.
REQ-010 SHALL have port stopin  output  1  high: pushin is not accepted this cycle.
REQ-011 SHALL have port stopout  input  1  downstream backpressure.
REQ-012 SHALL have port pushout  output  1  dout, doutix, tagout, lastout valid.
REQ-013 SHALL have port dout  output  DW  current chunk.
REQ-014 SHALL have port doutix  output  IXW  current chunk index.
REQ-015 SHALL have port tagout  output  8  tag of block being emitted.
REQ-016 SHALL have port lastout  output  1  current chunk is the block's final chunk.

Function
REQ-017 SHALL hold two block slots: ACTIVE (being emitted) and PENDING (waiting); each stores 1600-bit state, tag, chunk count.
REQ-018 SHALL drive stopin = PENDING occupied, from a register.
REQ-019 SHALL accept pushin only when stopin low; pushin while stopin high is dropped, no state change.
REQ-020 SHALL load an accepted block into ACTIVE if ACTIVE is empty or its final beat transfers this cycle with PENDING empty, else into PENDING.
REQ-021 SHALL clamp nchin to NCHUNK-1 when nchin >= NCHUNK.
REQ-022 SHALL implement FSM IDLE (ACTIVE empty) and SEND (ACTIVE occupied).
REQ-023 SHALL move IDLE->SEND on the edge an accepted block loads into ACTIVE; pushout rises the following cycle (latency 1 cycle).
REQ-024 SHALL assert pushout throughout SEND, including cycles with stopout high.
REQ-025 SHALL define a beat transfer as pushout high and stopout low at a rising edge.
REQ-026 SHALL drive dout = ACTIVE state bits DW*doutix+DW-1 : DW*doutix.
REQ-027 SHALL hold dout, doutix, tagout, lastout stable while pushout high and stopout high.
REQ-028 SHALL increment doutix by one on each non-final transfer, starting at 0 for every block.
REQ-029 SHALL assert lastout when doutix equals the block's stored chunk count.
REQ-030 SHALL on final transfer: move PENDING to ACTIVE, doutix 0, stay SEND, no bubble, if PENDING occupied; else load simultaneous accepted pushin into ACTIVE, stay SEND, no bubble; else go IDLE.
REQ-031 SHALL never emit a block partially or reorder blocks; blocks emit in acceptance order.
REQ-032 SHALL in IDLE drive pushout 0, lastout 0, doutix 0; dout and tagout hold last values.

Reset
REQ-033 SHALL on reset high at a clock edge clear both slots, enter IDLE, drive pushout 0, stopin 0, doutix 0, lastout 0, dout 0, tagout 0, regardless of activity.
REQ-034 SHALL ignore pushin in any cycle reset is high; abandoned blocks are never emitted.

Verification
REQ-035 SHALL cover: one block, nchin=7, stopout low -> pushout cycles 1..8, doutix 0..7, dout[k]=din[200k+199:200k], lastout only at index 7.
REQ-036 SHALL cover: nchin=1 (256-bit digest mode) -> exactly 2 beats, index 0,1, lastout on index 1, then IDLE.
REQ-037 SHALL cover: stopout high for 3 cycles at index 4 -> dout, doutix=4 held 3 cycles, 8 total transfers, no duplicates.
REQ-038 SHALL cover: three back-to-back pushins, tags 0x11,0x22,0x33 -> third dropped only if stopin high; accepted blocks emit contiguously, no idle cycle, tagout follows order.
REQ-039 SHALL cover: pushin on final-beat cycle with PENDING empty -> next block index 0 on next cycle, no bubble.
REQ-040 SHALL cover: reset asserted at index 3 with PENDING full -> next cycle pushout 0, stopin 0, no remaining beats emitted.
